// File: rtl/imm_decode_pipe_if.sv
// Instruction-in / immediate-out handshake bundle for imm_decode_pipe.
// The slave side is the decoder and the master side is the producer/consumer.
`timescale 1ns/1ps
interface imm_decode_pipe_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     inst;
   logic [2:0]      sel_i;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] imm;
   logic [2:0]      imm_type;
   logic            illegal;
   logic [15:0]     illegal_cnt;

   modport slave (
      input  in_valid, inst, sel_i, out_ready,
      output in_ready, out_valid, imm, imm_type, illegal, illegal_cnt
   );
   modport master (
      output in_valid, inst, sel_i, out_ready,
      input  in_ready, out_valid, imm, imm_type, illegal, illegal_cnt
   );
endinterface

// File: rtl/imm_decode_pipe.sv
// RISC-V immediate decoder: a combinational decode feeds a DEPTH-entry FIFO,
// so a result appears at the head one cycle after the instruction is accepted.
`timescale 1ns/1ps
module imm_decode_pipe #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 2,
   parameter int AUTO_DECODE = 1
) (
   input logic           clk,
   input logic           rst_n,
   imm_decode_pipe_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [2:0] SEL_I = 3'd0;
   localparam logic [2:0] SEL_S = 3'd1;
   localparam logic [2:0] SEL_B = 3'd2;
   localparam logic [2:0] SEL_U = 3'd3;
   localparam logic [2:0] SEL_J = 3'd4;
   localparam logic [2:0] SEL_Z = 3'd5;
   localparam logic [2:0] SEL_N = 3'd6;
   localparam logic [2:0] SEL_X = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      typ;
      logic            ill;
   } ent_t;

   logic [31:0]   i;
   logic [2:0]    sel;
   logic [31:0]   raw;
   ent_t          new_ent;
   ent_t          mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [15:0]   ill_cnt;
   logic          push, pop;

   assign i = bus.inst;

   always_comb begin
      sel = bus.sel_i;
      if (AUTO_DECODE != 0) begin
         case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: sel = SEL_I;
            7'b0011011: sel = (XLEN == 64) ? SEL_I : SEL_X;
            7'b1110011: sel = i[14] ? SEL_Z : SEL_I;
            7'b0100011: sel = SEL_S;
            7'b1100011: sel = SEL_B;
            7'b0110111, 7'b0010111: sel = SEL_U;
            7'b1101111: sel = SEL_J;
            7'b0110011: sel = SEL_N;
            7'b0111011: sel = (XLEN == 64) ? SEL_N : SEL_X;
            default:    sel = SEL_X;
         endcase
      end
   end

   // Every format is built as a 32-bit value and then sign-extended to XLEN;
   // Z stays positive because its top bits are zero.
   always_comb begin
      raw         = '0;
      new_ent     = '0;
      new_ent.typ = sel;
      case (sel)
         SEL_I:   raw = {{20{i[31]}}, i[31:20]};
         SEL_S:   raw = {{20{i[31]}}, i[31:25], i[11:7]};
         SEL_B:   raw = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         SEL_U:   raw = {i[31:12], 12'b0};
         SEL_J:   raw = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         SEL_Z:   raw = {27'b0, i[19:15]};
         SEL_N:   raw = '0;
         default: new_ent.ill = 1'b1;
      endcase
      new_ent.imm = XLEN'($signed(raw));
   end

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign bus.in_ready  = (count < CW'(DEPTH));
   assign bus.out_valid = (count != '0);
   assign push = bus.in_valid && bus.in_ready && rst_n;
   assign pop  = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= new_ent;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ill_cnt <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && new_ent.ill && ill_cnt != 16'hFFFF) ill_cnt <= ill_cnt + 1'b1;
      end
   end

   // Head fields are forced to zero whenever the FIFO is empty.
   assign bus.imm         = bus.out_valid ? mem[rd_ptr].imm : '0;
   assign bus.imm_type    = bus.out_valid ? mem[rd_ptr].typ : '0;
   assign bus.illegal     = bus.out_valid ? mem[rd_ptr].ill : 1'b0;
   assign bus.illegal_cnt = ill_cnt;
endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: scoreboarded 32-bit auto-decode instance plus
// table checks on a 64-bit instance and a manual-selector instance.
`timescale 1ns/1ps
module tb_imm_decode_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imm_decode_pipe_if #(.XLEN(32)) b32();
   imm_decode_pipe_if #(.XLEN(64)) b64();
   imm_decode_pipe_if #(.XLEN(32)) bm();

   imm_decode_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(1)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   imm_decode_pipe #(.XLEN(64), .DEPTH(3), .AUTO_DECODE(1)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));
   imm_decode_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(0)) um  (.clk(clk), .rst_n(rst_n), .bus(bm));

   typedef struct { logic [31:0] imm; logic [2:0] typ; logic ill; } exp_t;
   typedef struct { logic [31:0] inst; exp_t e; } vec_t;
   typedef struct { logic [31:0] inst; logic [2:0] sel; logic [63:0] imm; logic [2:0] typ; logic ill; } v64_t;

   int n_cmp = 0;
   int n_bad = 0;
   exp_t sb[$];
   exp_t cur_exp;
   exp_t prev_head;
   logic prev_hold = 1'b0;
   logic [15:0] exp_cnt = '0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h @%0t", nm, act, req, $time);
      end
   endtask

   // Scoreboard monitor for the 32-bit instance, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         exp_t e;
         check("illegal_cnt", 64'(b32.illegal_cnt), 64'(exp_cnt));
         if (b32.out_valid) begin
            if (prev_hold) begin
               check("hold_imm", 64'(b32.imm), 64'(prev_head.imm));
               check("hold_type", 64'(b32.imm_type), 64'(prev_head.typ));
               check("hold_ill", 64'(b32.illegal), 64'(prev_head.ill));
            end
            if (b32.out_ready) begin
               if (sb.size() == 0) check("sb_underflow", 64'(1), 64'(0));
               else begin
                  e = sb.pop_front();
                  check("imm", 64'(b32.imm), 64'(e.imm));
                  check("imm_type", 64'(b32.imm_type), 64'(e.typ));
                  check("illegal", 64'(b32.illegal), 64'(e.ill));
               end
            end
         end else begin
            check("idle_zero", {b32.imm, 28'(b32.imm_type), 4'(b32.illegal)}, 64'(0));
         end
         prev_hold = b32.out_valid && !b32.out_ready;
         prev_head = '{b32.imm, b32.imm_type, b32.illegal};
         if (b32.in_valid && b32.in_ready) begin
            sb.push_back(cur_exp);
            if (cur_exp.ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         end
      end else prev_hold = 1'b0;
   end

   // Entered and left at posedge+1.
   task automatic push32(input logic [31:0] ins, input exp_t e);
      logic acc;
      int n = 0;
      b32.inst = ins; cur_exp = e; b32.in_valid = 1'b1;
      forever begin
         @(negedge clk); acc = b32.in_ready;
         @(posedge clk); #1;
         if (acc) break;
         n++;
         if (n > 50) begin check("push_timeout", 64'(0), 64'(1)); break; end
      end
      b32.in_valid = 1'b0;
   endtask

   task automatic run64(input v64_t v);
      check("r64_ready", 64'(b64.in_ready), 64'(1));
      b64.inst = v.inst; b64.in_valid = 1'b1;
      @(posedge clk); #1; b64.in_valid = 1'b0;
      @(negedge clk);
      check("r64_valid", 64'(b64.out_valid), 64'(1));
      check("r64_imm", b64.imm, v.imm);
      check("r64_type", 64'(b64.imm_type), 64'(v.typ));
      check("r64_ill", 64'(b64.illegal), 64'(v.ill));
      @(posedge clk); #1;
   endtask

   task automatic runm(input v64_t v);
      check("rm_ready", 64'(bm.in_ready), 64'(1));
      bm.inst = v.inst; bm.sel_i = v.sel; bm.in_valid = 1'b1;
      @(posedge clk); #1; bm.in_valid = 1'b0;
      @(negedge clk);
      check("rm_valid", 64'(bm.out_valid), 64'(1));
      check("rm_imm", 64'(bm.imm), v.imm);
      check("rm_type", 64'(bm.imm_type), 64'(v.typ));
      check("rm_ill", 64'(bm.illegal), 64'(v.ill));
      @(posedge clk); #1;
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[15];
      v64_t t64[8];
      v64_t tm[10];
      exp_t eill;
      int n;
      eill = '{32'h0, 3'd7, 1'b1};
      tv[0]  = '{32'hFFF00093, '{32'hFFFFFFFF, 3'd0, 1'b0}};
      tv[1]  = '{32'h800000EF, '{32'hFFF00000, 3'd4, 1'b0}};
      tv[2]  = '{32'hFE002E23, '{32'hFFFFFFFC, 3'd1, 1'b0}};
      tv[3]  = '{32'h00000463, '{32'h00000008, 3'd2, 1'b0}};
      tv[4]  = '{32'h800000E3, '{32'hFFFFF800, 3'd2, 1'b0}};
      tv[5]  = '{32'h12345037, '{32'h12345000, 3'd3, 1'b0}};
      tv[6]  = '{32'h80000017, '{32'h80000000, 3'd3, 1'b0}};
      tv[7]  = '{32'hFFFFD073, '{32'h0000001F, 3'd5, 1'b0}};
      tv[8]  = '{32'hFFF01073, '{32'hFFFFFFFF, 3'd0, 1'b0}};
      tv[9]  = '{32'h00B50533, '{32'h00000000, 3'd6, 1'b0}};
      tv[10] = '{32'h0000001B, eill};
      tv[11] = '{32'h0000003B, eill};
      tv[12] = '{32'h0000007F, eill};
      tv[13] = '{32'h00402083, '{32'h00000004, 3'd0, 1'b0}};
      tv[14] = '{32'h00008067, '{32'h00000000, 3'd0, 1'b0}};
      t64[0] = '{32'h800002B7, 3'd0, 64'hFFFFFFFF80000000, 3'd3, 1'b0};
      t64[1] = '{32'h0000001B, 3'd0, 64'h0, 3'd0, 1'b0};
      t64[2] = '{32'h0000003B, 3'd0, 64'h0, 3'd6, 1'b0};
      t64[3] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
      t64[4] = '{32'h800000EF, 3'd0, 64'hFFFFFFFFFFF00000, 3'd4, 1'b0};
      t64[5] = '{32'h0000007F, 3'd0, 64'h0, 3'd7, 1'b1};
      t64[6] = '{32'hFFFFD073, 3'd0, 64'h1F, 3'd5, 1'b0};
      t64[7] = '{32'h800000E3, 3'd0, 64'hFFFFFFFFFFFFF800, 3'd2, 1'b0};
      tm[0] = '{32'hFFFFFFFF, 3'd0, 64'hFFFFFFFF, 3'd0, 1'b0};
      tm[1] = '{32'hFFFFFFFF, 3'd1, 64'hFFFFFFFF, 3'd1, 1'b0};
      tm[2] = '{32'hFFFFFFFF, 3'd2, 64'hFFFFFFFE, 3'd2, 1'b0};
      tm[3] = '{32'hFFFFFFFF, 3'd3, 64'hFFFFF000, 3'd3, 1'b0};
      tm[4] = '{32'hFFFFFFFF, 3'd4, 64'hFFFFFFFE, 3'd4, 1'b0};
      tm[5] = '{32'hFFFFFFFF, 3'd5, 64'h1F, 3'd5, 1'b0};
      tm[6] = '{32'hFFFFFFFF, 3'd6, 64'h0, 3'd6, 1'b0};
      tm[7] = '{32'hFFFFFFFF, 3'd7, 64'h0, 3'd7, 1'b1};
      tm[8] = '{32'h0000007F, 3'd0, 64'h0, 3'd0, 1'b0};
      tm[9] = '{32'h00000013, 3'd7, 64'h0, 3'd7, 1'b1};

      b32.in_valid = 0; b32.inst = 0; b32.sel_i = 0; b32.out_ready = 1;
      b64.in_valid = 0; b64.inst = 0; b64.sel_i = 0; b64.out_ready = 1;
      bm.in_valid = 0;  bm.inst = 0;  bm.sel_i = 0;  bm.out_ready = 1;
      cur_exp = eill;

      // Reset state
      #2;
      check("rst_out_valid", 64'(b32.out_valid), 64'(0));
      check("rst_in_ready", 64'(b32.in_ready), 64'(1));
      check("rst_imm", 64'(b32.imm), 64'(0));
      check("rst_cnt", 64'(b32.illegal_cnt), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Decode table, one entry at a time through an empty FIFO
      for (int k = 0; k < 15; k++) begin
         check("pre_empty", 64'(b32.out_valid), 64'(0));
         push32(tv[k].inst, tv[k].e);
         check("latency1", 64'(b32.out_valid), 64'(1));
         @(posedge clk); #1;
         check("drained", 64'(b32.out_valid), 64'(0));
      end

      // Backpressure with DEPTH=2
      b32.out_ready = 1'b0;
      push32(tv[13].inst, tv[13].e);
      push32(tv[5].inst, tv[5].e);
      check("bp_full", 64'(b32.in_ready), 64'(0));
      b32.inst = tv[0].inst; cur_exp = tv[0].e; b32.in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("bp_blocked", 64'(b32.in_ready), 64'(0));
      check("bp_head", 64'(b32.imm), 64'(tv[13].e.imm));
      b32.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_reraise", 64'(b32.in_ready), 64'(1));
      @(posedge clk); #1; b32.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("bp_drained", 64'(b32.out_valid), 64'(0));

      // Streaming push+pop keeps exactly one entry in flight
      b32.in_valid = 1'b1;
      for (int k = 0; k < 11; k++) begin
         b32.inst = (32'(k + 1) << 20) | 32'h13;
         cur_exp = '{32'(k + 1), 3'd0, 1'b0};
         @(posedge clk); #1;
         check("stream_ready", 64'(b32.in_ready), 64'(1));
         check("stream_valid", 64'(b32.out_valid), 64'(1));
      end
      b32.in_valid = 1'b0;
      @(posedge clk); #1;
      check("stream_drained", 64'(b32.out_valid), 64'(0));

      // Counter saturation: stream illegal entries up to 0xFFFE
      b32.inst = 32'h7F; cur_exp = eill; b32.in_valid = 1'b1;
      n = 0;
      while (exp_cnt != 16'hFFFE && n < 70000) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 70000) check("sat_timeout", 64'(0), 64'(1));
      @(posedge clk); #1; b32.in_valid = 1'b0;
      @(negedge clk) check("sat_preload", 64'(b32.illegal_cnt), 64'hFFFE);
      @(posedge clk); #1;
      push32(32'h7F, eill);
      push32(32'h7F, eill);
      @(negedge clk) check("sat_max", 64'(b32.illegal_cnt), 64'hFFFF);
      @(posedge clk); #1;
      push32(32'h7F, eill);
      @(negedge clk) check("sat_hold", 64'(b32.illegal_cnt), 64'hFFFF);
      @(posedge clk); #1;

      // Asynchronous reset with two queued entries
      b32.out_ready = 1'b0;
      push32(32'h7F, eill);
      push32(32'h7F, eill);
      check("q2_full", 64'(b32.in_ready), 64'(0));
      #2 rst_n = 1'b0;
      sb.delete();
      exp_cnt = '0;
      #1;
      check("arst_out_valid", 64'(b32.out_valid), 64'(0));
      check("arst_cnt", 64'(b32.illegal_cnt), 64'(0));
      check("arst_imm", {b32.imm, 28'(b32.imm_type), 4'(b32.illegal)}, 64'(0));
      check("arst_in_ready", 64'(b32.in_ready), 64'(1));
      b32.inst = 32'h13; b32.in_valid = 1'b1; b32.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; b32.in_valid = 1'b0;
      check("no_push_in_reset", 64'(b32.out_valid), 64'(0));
      @(posedge clk); #1;
      push32(tv[1].inst, tv[1].e);
      check("post_rst_latency", 64'(b32.out_valid), 64'(1));
      @(posedge clk); #1;

      // 64-bit and manual-selector instances
      for (int k = 0; k < 8; k++) run64(t64[k]);
      check("r64_cnt", 64'(b64.illegal_cnt), 64'(1));
      for (int k = 0; k < 10; k++) runm(tm[k]);
      check("rm_cnt", 64'(bm.illegal_cnt), 64'(2));

      check("sb_drain", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 The block SHALL have the parameter XLEN, default 32, which sets the immediate width; the legal values are 32 and 64.
REQ-002 The block SHALL have the parameter DEPTH, default 2, which sets the number of output FIFO entries; the legal range is 1..8.
REQ-003 The block SHALL have the parameter AUTO_DECODE, default 1: 1 derives the selector from the opcode, 0 uses the sel_i port.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have the port in_valid, input, 1 bit: the instruction is valid.
REQ-007 The block SHALL have the port in_ready, output, 1 bit: the block can accept an instruction.
REQ-008 The block SHALL have the port inst, input, 32 bits: the full instruction word.
REQ-009 The block SHALL have the port sel_i, input, 3 bits: the external selector, used only when AUTO_DECODE=0.
REQ-010 The block SHALL have the port out_valid, output, 1 bit: the FIFO head is valid.
REQ-011 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts the head.
REQ-012 The block SHALL have the port imm, output, XLEN bits: the head immediate.
REQ-013 The block SHALL have the port imm_type, output, 3 bits: the head selector actually applied.
REQ-014 The block SHALL have the port illegal, output, 1 bit: the head has an unrecognised opcode or selector.
REQ-015 The block SHALL have the port illegal_cnt, output, 16 bits: a saturating count of illegal entries accepted.

Function
REQ-016 The selector encodings SHALL be: I=0, S=1, B=2, U=3, J=4, Z=5 (CSR uimm), N=6 (no immediate), 7=invalid.
REQ-017 With sel=I, imm SHALL be the sign-extension of inst[31:20] to XLEN.
REQ-018 With sel=S, imm SHALL be the sign-extension of {inst[31:25],inst[11:7]}.
REQ-019 With sel=B, imm SHALL be the sign-extension of {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
REQ-020 With sel=U, imm SHALL be the sign-extension of {inst[31:12],12'b0}; for XLEN=64, bits 63:32 SHALL equal inst[31].
REQ-021 With sel=J, imm SHALL be the sign-extension of {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
REQ-022 With sel=Z, imm SHALL be the zero-extension of inst[19:15].
REQ-023 With sel=N, imm SHALL be 0 and illegal SHALL be 0.
REQ-024 With sel=7, imm SHALL be 0 and illegal SHALL be 1.
REQ-025 With AUTO_DECODE=1, the selector SHALL be derived from opcode=inst[6:0] as follows:
- 0010011, 0000011, 1100111 -> I
- 0011011 -> I when XLEN=64, else 7
- 1110011 -> Z when inst[14]=1, else I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- 0110011 -> N; 0111011 -> N when XLEN=64, else 7
- any other opcode -> 7
REQ-026 An instruction SHALL be accepted on a rising edge when in_valid=1 and in_ready=1; its result SHALL be computed combinationally and written to the FIFO tail.
REQ-027 Latency SHALL be 1 cycle: an entry accepted at edge k SHALL appear at the head no earlier than after edge k, when the FIFO was empty.
REQ-028 in_ready SHALL equal (count < DEPTH) and SHALL be registered-state based only, with no combinational path from out_ready; there is no full-FIFO bypass.
REQ-029 An entry SHALL be popped on an edge where out_valid=1 and out_ready=1; out_valid SHALL equal (count != 0).
REQ-030 On a simultaneous push and pop, count SHALL remain unchanged and ordering SHALL be preserved.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; results SHALL be delivered strictly in acceptance order.
REQ-032 While out_valid=1 and out_ready=0, imm, imm_type and illegal SHALL hold stable.
REQ-033 When out_valid=0, imm, imm_type and illegal SHALL be 0.
REQ-034 illegal_cnt SHALL increment on each accepted entry whose illegal=1, SHALL saturate at 16'hFFFF, and SHALL be unaffected by pops.

Reset
REQ-035 rst_n=0 SHALL immediately, without waiting for clk, clear count, pointers and illegal_cnt, and drive out_valid=0, imm=0, imm_type=0, illegal=0.
REQ-036 During reset, in_ready SHALL be 1 and no push SHALL occur.
REQ-037 Entries in flight when reset asserts mid-operation SHALL be discarded.
REQ-038 After rst_n deasserts, the first accepting edge SHALL behave as in REQ-026.

Verification
REQ-039 Decode, XLEN=32, AUTO=1: push 0xFFF00093 -> imm=0xFFFFFFFF, type=0; push 0x800000EF -> imm=0xFFF00000, type=4.
REQ-040 XLEN=64: push 0x800002B7 (lui) -> imm=0xFFFFFFFF80000000; push 0x0000001B -> type=0, illegal=0.
REQ-041 Backpressure, DEPTH=2: hold out_ready=0 and push 3 items -> in_ready=0 after 2 are accepted; head stays stable; the first pop re-raises in_ready.
REQ-042 Simultaneous push/pop with count=1 for 10 cycles -> count stays 1 and outputs appear in order with 1-cycle latency.
REQ-043 Illegal: push opcode 0x7F and sel_i=7 (AUTO=0) -> illegal=1, imm=0, illegal_cnt=2; preload at 0xFFFE and push 2 illegal -> illegal_cnt=0xFFFF.
REQ-044 Assert rst_n low asynchronously with 2 entries queued -> out_valid=0 and illegal_cnt=0 before the next clk edge.
